frac_sched: RTL and testbench

//  Frame scheduler for a pool of NUM_ENG frac_calc engines. Walks an H_SIZE x V_SIZE pixel grid
//  in raster order starting at (x0,y0) with steps (dx,dy). Dispatches each pixel's (cx,cy) to a

---
 rtl/frac_pkg.sv | 20 ++
 rtl/frac_sched_rr_arb.sv | 49 ++++
 rtl/frac_sched.sv | 188 ++++++++++++++++++
 tb/tb_frac_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_pkg.sv
// Shared defaults and encodings for the fractal frame scheduler.
// The pixel address is the {row,col} pair, so its width is twice the per-axis width.
package frac_pkg;

    localparam int FRAC_N       = 32;
    localparam int FRAC_M       = 4;
    localparam int FRAC_AW      = 10;
    localparam int FRAC_NUM_ENG = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    function automatic int pix_aw(input int aw);
        return 2 * aw;
    endfunction

endpackage

// File: rtl/frac_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// When adv is high, the pointer moves to one past the granted requester.
module rr_arb #(
    parameter int NUM = 4
) (
    input  logic           frac_clk,
    input  logic           frac_rst,
    input  logic [NUM-1:0] req,
    input  logic           adv,
    output logic [NUM-1:0] gnt
);

    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] cand_idx;
    logic          hit;
    int            cand;

    always_comb begin
        gnt      = '0;
        ptr_nxt  = ptr;
        hit      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            cand_idx = PW'(cand);
            if (!hit && req[cand_idx]) begin
                hit           = 1'b1;
                gnt[cand_idx] = 1'b1;
                ptr_nxt       = (cand == NUM - 1) ? '0 : PW'(cand + 1);
            end
        end
    end

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/frac_sched.sv
// Frame scheduler: walks the pixel grid in raster order, dispatches coordinates to a pool of
// frac_calc engines and streams one {row,col}/found result per pixel, possibly out of order.
//
// state    | meaning
// ST_IDLE  | waiting for start; config inputs latched on start
// ST_RUN   | dispatching pixels, at most one per cycle, while collecting results
// ST_DRAIN | all pixels dispatched; waiting for engines free and output register empty
module frac_sched
    import frac_pkg::*;
#(
    parameter int N       = FRAC_N,
    parameter int M       = FRAC_M,
    parameter int NUM_ENG = FRAC_NUM_ENG,
    parameter int AW      = FRAC_AW
) (
    input  logic                  frac_clk,
    input  logic                  frac_rst,
    input  logic                  start,
    input  logic [N-1:0]          x0,
    input  logic [N-1:0]          y0,
    input  logic [N-1:0]          dx,
    input  logic [N-1:0]          dy,
    input  logic [AW-1:0]         h_size,
    input  logic [AW-1:0]         v_size,
    input  logic [15:0]           max_iter,
    output logic                  busy,
    output logic                  frame_done,
    output logic [NUM_ENG-1:0]    eng_go,
    output logic [N-1:0]          eng_cx,
    output logic [N-1:0]          eng_cy,
    output logic [15:0]           eng_iter,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [NUM_ENG-1:0]    eng_found,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [pix_aw(AW)-1:0] pix_addr,
    output logic                  pix_found
);

    localparam int PAW = pix_aw(AW);

    if (M < 1 || M >= N || NUM_ENG < 1 || NUM_ENG > 16) begin : g_bad_cfg
        $error("frac_sched: unsupported parameter set");
    end

    sched_state_t state, state_nxt;

    logic [N-1:0]       x0_q, dx_q, dy_q, cur_cx, cur_cy;
    logic [AW-1:0]      h_q, v_q, col, row;
    logic [NUM_ENG-1:0] eng_busy, req_d, req_c, gnt_d, gnt_c;
    logic [PAW-1:0]     tag [NUM_ENG];
    logic [PAW-1:0]     col_tag;
    logic               col_found;
    logic               run_en, load_cfg, empty_cfg, drain_ok, out_free;
    logic               dispatch, collect, last_pix;

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start && !empty_cfg)   state_nxt = ST_RUN;
            ST_RUN:   if (dispatch && last_pix)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_ok)              state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        run_en   = (state == ST_RUN);
        load_cfg = (state == ST_IDLE) && start;
        drain_ok = (state == ST_DRAIN) && (eng_busy == '0) && !pix_valid;
    end

    assign empty_cfg = (h_size == '0) || (v_size == '0);
    assign out_free  = !pix_valid || pix_ready;
    assign last_pix  = (col == h_q - 1'b1) && (row == v_q - 1'b1);

    // eng_done from an engine's previous job may still be high in its go cycle; mask it.
    assign req_d    = run_en ? ~eng_busy : '0;
    assign req_c    = out_free ? (eng_busy & eng_done & ~eng_go) : '0;
    assign dispatch = |gnt_d;
    assign collect  = |gnt_c;

    rr_arb #(.NUM(NUM_ENG)) u_arb_go (
        .frac_clk (frac_clk),
        .frac_rst (frac_rst),
        .req      (req_d),
        .adv      (dispatch),
        .gnt      (gnt_d)
    );

    rr_arb #(.NUM(NUM_ENG)) u_arb_col (
        .frac_clk (frac_clk),
        .frac_rst (frac_rst),
        .req      (req_c),
        .adv      (collect),
        .gnt      (gnt_c)
    );

    always_comb begin
        col_tag   = '0;
        col_found = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (gnt_c[i]) begin
                col_tag   = tag[i];
                col_found = eng_found[i];
            end
        end
    end

    always_ff @(posedge frac_clk or posedge frac_rst) begin
        if (frac_rst) begin
            x0_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            h_q        <= '0;
            v_q        <= '0;
            cur_cx     <= '0;
            cur_cy     <= '0;
            col        <= '0;
            row        <= '0;
            eng_iter   <= '0;
            eng_go     <= '0;
            eng_cx     <= '0;
            eng_cy     <= '0;
            eng_busy   <= '0;
            frame_done <= 1'b0;
            pix_valid  <= 1'b0;
            pix_addr   <= '0;
            pix_found  <= 1'b0;
            for (int i = 0; i < NUM_ENG; i++) begin
                tag[i] <= '0;
            end
        end else begin
            frame_done <= drain_ok || (load_cfg && empty_cfg);
            eng_go     <= gnt_d;
            eng_busy   <= (eng_busy | gnt_d) & ~gnt_c;

            if (load_cfg) begin
                x0_q     <= x0;
                dx_q     <= dx;
                dy_q     <= dy;
                h_q      <= h_size;
                v_q      <= v_size;
                eng_iter <= max_iter;
                cur_cx   <= x0;
                cur_cy   <= y0;
                col      <= '0;
                row      <= '0;
            end else if (dispatch) begin
                eng_cx <= cur_cx;
                eng_cy <= cur_cy;
                if (col == h_q - 1'b1) begin
                    col    <= '0;
                    cur_cx <= x0_q;
                    row    <= row + 1'b1;
                    cur_cy <= cur_cy + dy_q;
                end else begin
                    col    <= col + 1'b1;
                    cur_cx <= cur_cx + dx_q;
                end
            end

            for (int i = 0; i < NUM_ENG; i++) begin
                if (gnt_d[i]) begin
                    tag[i] <= {row, col};
                end
            end

            if (collect) begin
                pix_valid <= 1'b1;
                pix_addr  <= col_tag;
                pix_found <= col_found;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frac_sched.sv
// Directed bench for frac_sched with a behavioural model of four frac_calc engines.
// Engines answer after a per-engine latency; found = cx[24] ^ cy[24] of the dispatched point.
module tb_frac_sched;

    localparam int NE = 4;

    logic        frac_clk = 1'b0;
    logic        frac_rst;
    logic        start;
    logic [31:0] x0, y0, dx, dy;
    logic [9:0]  h_size, v_size;
    logic [15:0] max_iter;
    logic        busy, frame_done;
    logic [3:0]  eng_go;
    logic [31:0] eng_cx, eng_cy;
    logic [15:0] eng_iter;
    logic [3:0]  eng_done, eng_found;
    logic        pix_valid, pix_ready;
    logic [19:0] pix_addr;
    logic        pix_found;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 frac_clk = ~frac_clk;

    frac_sched #(.N(32), .M(4), .NUM_ENG(NE), .AW(10)) dut (
        .frac_clk   (frac_clk),
        .frac_rst   (frac_rst),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .dx         (dx),
        .dy         (dy),
        .h_size     (h_size),
        .v_size     (v_size),
        .max_iter   (max_iter),
        .busy       (busy),
        .frame_done (frame_done),
        .eng_go     (eng_go),
        .eng_cx     (eng_cx),
        .eng_cy     (eng_cy),
        .eng_iter   (eng_iter),
        .eng_done   (eng_done),
        .eng_found  (eng_found),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_addr   (pix_addr),
        .pix_found  (pix_found)
    );

    // engine model
    int   lat [NE];
    int   cnt [NE];
    logic fnd_pend [NE];

    initial begin
        eng_done  = '0;
        eng_found = '0;
        for (int i = 0; i < NE; i++) begin
            cnt[i]      = 0;
            fnd_pend[i] = 1'b0;
        end
        forever begin
            @(posedge frac_clk or posedge frac_rst);
            #1;
            if (frac_rst) begin
                eng_done  = '0;
                eng_found = '0;
                for (int i = 0; i < NE; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NE; i++) begin
                    if (eng_go[i]) begin
                        eng_done[i]  = 1'b0;
                        eng_found[i] = 1'b0;
                        cnt[i]       = lat[i];
                        fnd_pend[i]  = eng_cx[24] ^ eng_cy[24];
                    end else if (cnt[i] > 0) begin
                        cnt[i] = cnt[i] - 1;
                        if (cnt[i] == 0) begin
                            eng_done[i]  = 1'b1;
                            eng_found[i] = fnd_pend[i];
                        end
                    end
                end
            end
        end
    end

    // observation log, sampled mid-cycle
    int          cyc = 0;
    int          go_cnt = 0;
    int          fd_cnt = 0;
    int          multi_go = 0;
    logic [31:0] g_cx [$];
    logic [31:0] g_cy [$];
    logic [19:0] r_addr [$];
    logic        r_found [$];
    int          r_cyc [$];

    always @(negedge frac_clk) begin
        cyc = cyc + 1;
        if (eng_go != 4'b0) begin
            go_cnt = go_cnt + 1;
            g_cx.push_back(eng_cx);
            g_cy.push_back(eng_cy);
            if ($countones(eng_go) != 1) multi_go = multi_go + 1;
        end
        if (pix_valid && pix_ready) begin
            r_addr.push_back(pix_addr);
            r_found.push_back(pix_found);
            r_cyc.push_back(cyc);
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frac_clk);
            #1;
        end
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    task automatic do_reset();
        frac_rst = 1'b1;
        tick(2);
        frac_rst = 1'b0;
        tick(1);
    endtask

    task automatic do_start(input logic [31:0] a_x0, input logic [31:0] a_y0,
                            input logic [31:0] a_dx, input logic [31:0] a_dy,
                            input logic [9:0] a_h, input logic [9:0] a_v,
                            input logic [15:0] a_it);
        x0 = a_x0; y0 = a_y0; dx = a_dx; dy = a_dy;
        h_size = a_h; v_size = a_v; max_iter = a_it;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_fd(input int base, input int budget, output bit ok);
        int k;
        k = 0;
        while (fd_cnt == base && k < budget) begin
            tick(1);
            k++;
        end
        ok = (fd_cnt != base);
    endtask

    task automatic test_reset();
        #2;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        vec_cnt++; if (eng_go !== 4'b0) begin err_cnt++; $display("FAIL rst_eng_go: got %b want 0000", eng_go); end
        vec_cnt++; if (pix_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_pix_valid: got %b want 0", pix_valid); end
        vec_cnt++; if ({eng_cx, eng_cy} !== 64'h0) begin err_cnt++; $display("FAIL rst_eng_cxcy: got %h want 0", {eng_cx, eng_cy}); end
        vec_cnt++; if (eng_iter !== 16'h0) begin err_cnt++; $display("FAIL rst_eng_iter: got %h want 0", eng_iter); end
        vec_cnt++; if ({pix_addr, pix_found} !== 21'h0) begin err_cnt++; $display("FAIL rst_pix_out: got %h want 0", {pix_addr, pix_found}); end
        tick(2);
        frac_rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_frame();
        int gb, rb, fb, mb, dup, bad;
        bit ok;
        logic [7:0] seen;
        logic [9:0] c, r;
        logic       ef;
        gb = go_cnt; rb = r_addr.size(); fb = fd_cnt; mb = multi_go;
        set_lat(3, 5, 2, 4);
        pix_ready = 1'b1;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd2, 16'd100);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_fd(fb, 300, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL basic_timeout: got no frame_done want one"); end
        tick(3);
        seen = '0; dup = 0; bad = 0;
        for (int k = rb; k < r_addr.size(); k++) begin
            c = r_addr[k][9:0]; r = r_addr[k][19:10];
            if (r < 2 && c < 4 && !seen[r*4+c]) seen[r*4+c] = 1'b1;
            else dup++;
            ef = c[0] ^ r[0];
            if (r_found[k] !== ef) bad++;
        end
        vec_cnt++; if (go_cnt - gb != 8) begin err_cnt++; $display("FAIL basic_go_cnt: got %0d want 8", go_cnt - gb); end
        vec_cnt++; if (r_addr.size() - rb != 8) begin err_cnt++; $display("FAIL basic_res_cnt: got %0d want 8", r_addr.size() - rb); end
        vec_cnt++; if (fd_cnt - fb != 1) begin err_cnt++; $display("FAIL basic_fd_cnt: got %0d want 1", fd_cnt - fb); end
        vec_cnt++; if (seen !== 8'hFF || dup != 0) begin err_cnt++; $display("FAIL basic_addr_set: got %b dup %0d want 11111111 dup 0", seen, dup); end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL basic_found: got %0d wrong want 0", bad); end
        vec_cnt++; if (eng_iter !== 16'd100) begin err_cnt++; $display("FAIL basic_iter: got %0d want 100", eng_iter); end
        vec_cnt++; if (multi_go != mb) begin err_cnt++; $display("FAIL basic_onehot: got %0d multi-hot go want 0", multi_go - mb); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_coords();
        int gb, fb;
        bit ok;
        logic [31:0] ecx, ecy;
        gb = go_cnt; fb = fd_cnt;
        set_lat(2, 2, 2, 2);
        pix_ready = 1'b1;
        do_start(32'h0, 32'h0030_0000, 32'h0100_0000, 32'h0200_0000, 10'd3, 10'd2, 16'd20);
        wait_fd(fb, 200, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL coords_timeout: got no frame_done want one"); end
        vec_cnt++; if (go_cnt - gb != 6) begin err_cnt++; $display("FAIL coords_go_cnt: got %0d want 6", go_cnt - gb); end
        for (int k = 0; k < 6 && gb + k < g_cx.size(); k++) begin
            ecx = 32'(k % 3) * 32'h0100_0000;
            ecy = 32'h0030_0000 + 32'(k / 3) * 32'h0200_0000;
            vec_cnt++; if (g_cx[gb+k] !== ecx) begin err_cnt++; $display("FAIL coords_cx%0d: got %h want %h", k, g_cx[gb+k], ecx); end
            vec_cnt++; if (g_cy[gb+k] !== ecy) begin err_cnt++; $display("FAIL coords_cy%0d: got %h want %h", k, g_cy[gb+k], ecy); end
        end
    endtask

    task automatic test_backpressure();
        int rb, fb, gw;
        bit ok;
        logic [3:0] seen;
        pix_ready = 1'b0;
        set_lat(2, 2, 2, 2);
        rb = r_addr.size(); fb = fd_cnt;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd2, 16'd5);
        tick(10);
        gw = go_cnt;
        for (int k = 0; k < 20; k++) begin
            vec_cnt++; if (pix_valid !== 1'b1 || pix_addr !== 20'h0) begin
                err_cnt++; $display("FAIL bp_hold%0d: got valid %b addr %h want valid 1 addr 00000", k, pix_valid, pix_addr);
            end
            tick(1);
        end
        vec_cnt++; if (go_cnt != gw) begin err_cnt++; $display("FAIL bp_no_go: got %0d new go want 0", go_cnt - gw); end
        pix_ready = 1'b1;
        tick(4);
        vec_cnt++; if (r_addr.size() - rb != 4) begin err_cnt++; $display("FAIL bp_burst_cnt: got %0d want 4", r_addr.size() - rb); end
        seen = '0;
        for (int k = rb; k < r_addr.size() && k < rb + 4; k++) begin
            if (r_addr[k][19:10] == 10'd0 && r_addr[k][9:0] < 10'd4) seen[r_addr[k][1:0]] = 1'b1;
        end
        vec_cnt++; if (seen !== 4'hF) begin err_cnt++; $display("FAIL bp_burst_set: got %b want 1111", seen); end
        if (r_addr.size() - rb >= 4) begin
            vec_cnt++; if (r_cyc[rb+3] - r_cyc[rb] != 3) begin err_cnt++; $display("FAIL bp_burst_span: got %0d cycles want 3", r_cyc[rb+3] - r_cyc[rb]); end
        end
        wait_fd(fb, 200, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL bp_timeout: got no frame_done want one"); end
        vec_cnt++; if (r_addr.size() - rb != 8) begin err_cnt++; $display("FAIL bp_res_cnt: got %0d want 8", r_addr.size() - rb); end
    endtask

    task automatic test_simul_done();
        int rb, fb;
        bit ok;
        do_reset();
        set_lat(4, 30, 2, 30);
        pix_ready = 1'b1;
        rb = r_addr.size(); fb = fd_cnt;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd1, 16'd9);
        wait_fd(fb, 200, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL simul_timeout: got no frame_done want one"); end
        vec_cnt++; if (r_addr.size() - rb != 4) begin err_cnt++; $display("FAIL simul_res_cnt: got %0d want 4", r_addr.size() - rb); end
        if (r_addr.size() - rb >= 2) begin
            vec_cnt++; if (r_addr[rb] !== 20'd0) begin err_cnt++; $display("FAIL simul_first: got %h want 00000", r_addr[rb]); end
            vec_cnt++; if (r_addr[rb+1] !== 20'd2) begin err_cnt++; $display("FAIL simul_second: got %h want 00002", r_addr[rb+1]); end
            vec_cnt++; if (r_cyc[rb+1] - r_cyc[rb] != 1) begin err_cnt++; $display("FAIL simul_gap: got %0d want 1", r_cyc[rb+1] - r_cyc[rb]); end
        end
    endtask

    task automatic test_empty_and_ignore();
        int gb, rb, fb, bad;
        bit ok;
        logic [31:0] ecx;
        gb = go_cnt; fb = fd_cnt;
        pix_ready = 1'b1;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd0, 16'd3);
        vec_cnt++; if (frame_done !== 1'b1) begin err_cnt++; $display("FAIL empty_fd: got %b want 1", frame_done); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL empty_busy: got %b want 0", busy); end
        tick(1);
        vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL empty_fd_pulse: got %b want 0", frame_done); end
        tick(3);
        vec_cnt++; if (go_cnt != gb) begin err_cnt++; $display("FAIL empty_no_go: got %0d go want 0", go_cnt - gb); end
        set_lat(10, 10, 10, 10);
        gb = go_cnt; rb = r_addr.size(); fb = fd_cnt;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd2, 16'd50);
        tick(3);
        do_start(32'h7000_0000, 32'h7000_0000, 32'h0, 32'h0, 10'd1, 10'd1, 16'd7);
        wait_fd(fb, 300, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL ign_timeout: got no frame_done want one"); end
        tick(3);
        vec_cnt++; if (go_cnt - gb != 8) begin err_cnt++; $display("FAIL ign_go_cnt: got %0d want 8", go_cnt - gb); end
        vec_cnt++; if (r_addr.size() - rb != 8) begin err_cnt++; $display("FAIL ign_res_cnt: got %0d want 8", r_addr.size() - rb); end
        vec_cnt++; if (fd_cnt - fb != 1) begin err_cnt++; $display("FAIL ign_fd_cnt: got %0d want 1", fd_cnt - fb); end
        vec_cnt++; if (eng_iter !== 16'd50) begin err_cnt++; $display("FAIL ign_iter: got %0d want 50", eng_iter); end
        bad = 0;
        for (int k = gb; k < g_cx.size(); k++) begin
            ecx = 32'((k - gb) % 4) * 32'h0100_0000;
            if (g_cx[k] !== ecx) bad++;
        end
        vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL ign_cx: got %0d wrong want 0", bad); end
    endtask

    task automatic test_reset_midframe();
        int rb, fb, gb, dup;
        bit ok;
        logic [3:0] seen;
        set_lat(10, 10, 10, 10);
        pix_ready = 1'b1;
        fb = fd_cnt;
        do_start(32'h0080_0000, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd4, 10'd2, 16'd33);
        tick(6);
        #3;
        frac_rst = 1'b1;
        #1;
        vec_cnt++; if ({busy, frame_done, eng_go, pix_valid} !== 7'b0) begin
            err_cnt++; $display("FAIL mrst_ctrl: got %b want 0000000", {busy, frame_done, eng_go, pix_valid});
        end
        vec_cnt++; if ({eng_cx, eng_cy, eng_iter} !== 80'h0) begin
            err_cnt++; $display("FAIL mrst_data: got %h want 0", {eng_cx, eng_cy, eng_iter});
        end
        tick(2);
        frac_rst = 1'b0;
        tick(2);
        vec_cnt++; if (fd_cnt != fb) begin err_cnt++; $display("FAIL mrst_no_fd: got %0d want 0", fd_cnt - fb); end
        set_lat(1, 2, 3, 1);
        gb = go_cnt; rb = r_addr.size(); fb = fd_cnt;
        do_start(32'h0, 32'h0, 32'h0100_0000, 32'h0100_0000, 10'd2, 10'd2, 16'd12);
        wait_fd(fb, 200, ok);
        vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL mrst_timeout: got no frame_done want one"); end
        tick(3);
        seen = '0; dup = 0;
        for (int k = rb; k < r_addr.size(); k++) begin
            if (r_addr[k][19:11] == 9'd0 && r_addr[k][9:1] == 9'd0 && !seen[{r_addr[k][10], r_addr[k][0]}])
                seen[{r_addr[k][10], r_addr[k][0]}] = 1'b1;
            else dup++;
        end
        vec_cnt++; if (go_cnt - gb != 4) begin err_cnt++; $display("FAIL mrst_go_cnt: got %0d want 4", go_cnt - gb); end
        vec_cnt++; if (seen !== 4'hF || dup != 0) begin err_cnt++; $display("FAIL mrst_addr_set: got %b dup %0d want 1111 dup 0", seen, dup); end
        vec_cnt++; if (fd_cnt - fb != 1) begin err_cnt++; $display("FAIL mrst_fd_cnt: got %0d want 1", fd_cnt - fb); end
    endtask

    initial begin
        frac_rst = 1'b0;
        start = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; y0 = '0; dx = '0; dy = '0;
        h_size = '0; v_size = '0; max_iter = '0;
        set_lat(1, 1, 1, 1);
        #1;
        frac_rst = 1'b1;
        test_reset();
        test_basic_frame();
        test_coords();
        test_backpressure();
        test_simul_done();
        test_empty_and_ignore();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of run want finish before 300000");
        $fatal(1);
    end

endmodule
